// File: rtl/kbd_line_buffer.sv
// kbd_line_buffer
//   Collects characters from a PS/2 keyboard controller into a one-line text
//   buffer in the clk domain. Backspace deletes the last character. Tab pads
//   with spaces up to the next tab stop. Enter hands the line to the consumer,
//   and the consumer releases it again with line_ack.
//
//   state      | meaning
//   EDIT       | accepting events, at most one buffer write per cycle
//   FILL       | writing tab padding, one space per cycle; events held pending
//   LINE_READY | line committed and frozen until line_ack
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   code[7:0]           key code, quasi-static while flag is high
//   flag                character strobe (async)
//   enter/tab/backspace key levels (async)
//   rd_addr, rd_char    registered read port into the buffer
//   length              number of characters held (0..DEPTH)
//   line_valid          a committed line is waiting
//   line_ack            consumer releases the committed line
//   overflow            sticky: a character was dropped on a full buffer
module kbd_line_buffer #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int TAB_STOP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        code,
  input  logic              flag,
  input  logic              enter,
  input  logic              tab,
  input  logic              backspace,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_char,
  output logic [ADDR_W:0]   length,
  output logic              line_valid,
  input  logic              line_ack,
  output logic              overflow
);

  typedef enum logic [1:0] {EDIT, FILL, LINE_READY} state_t;

  localparam int TS_M = TAB_STOP - 1;
  localparam logic [ADDR_W:0] FULL    = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] TS_MASK = TS_M[ADDR_W:0];

  // Event bit order is also the priority order: [3] enter, [2] bs, [1] tab, [0] char.
  function automatic logic [3:0] prio(input logic [3:0] e);
    if (e[3])      return 4'b1000;
    else if (e[2]) return 4'b0100;
    else if (e[1]) return 4'b0010;
    else if (e[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  logic [7:0]        mem [DEPTH];
  logic [3:0]        in_vec, s1, s2, prev, ev, pend, act;
  logic [7:0]        code_q;
  state_t            state;
  logic [ADDR_W:0]   len_inc;
  logic              not_full, on_stop, wr_en;
  logic [7:0]        wr_data;

  assign in_vec = {enter, backspace, tab, flag};

  // Two-flop synchroniser, then a registered rising-edge detector.
  // code is sampled on the edge that raises ev_char; it has been stable for
  // the whole synchroniser delay by then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      prev   <= '0;
      ev     <= '0;
      code_q <= 8'h00;
    end else begin
      s1   <= in_vec;
      s2   <= s1;
      prev <= s2;
      ev   <= s2 & ~prev;
      if (s2[0] && !prev[0]) code_q <= code;
    end
  end

  always_comb begin
    len_inc  = length + {{ADDR_W{1'b0}}, 1'b1};
    not_full = (length != FULL);
    on_stop  = ((len_inc & TS_MASK) == '0);
    // Events held during FILL compete with fresh ones in the first EDIT cycle.
    act      = (state == EDIT) ? prio(pend | ev) : 4'b0000;
    wr_en    = 1'b0;
    wr_data  = 8'h20;
    if (state == FILL) begin
      wr_en = 1'b1;
    end else if (act[1] && not_full) begin
      wr_en = 1'b1;
    end else if (act[0] && not_full) begin
      wr_en   = 1'b1;
      wr_data = code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[length[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EDIT;
      length     <= '0;
      line_valid <= 1'b0;
      overflow   <= 1'b0;
      pend       <= '0;
      rd_char    <= 8'h00;
    end else begin
      rd_char <= mem[rd_addr];
      case (state)
        EDIT: begin
          pend <= '0;
          if (act[3]) begin
            line_valid <= 1'b1;
            state      <= LINE_READY;
          end else if (act[2]) begin
            if (length != '0) length <= length - {{ADDR_W{1'b0}}, 1'b1};
          end else if (act[1]) begin
            if (not_full) begin
              length <= len_inc;
              if (!on_stop && len_inc != FULL) state <= FILL;
            end
          end else if (act[0]) begin
            if (not_full) length   <= len_inc;
            else          overflow <= 1'b1;
          end
        end
        FILL: begin
          pend   <= prio(pend | ev);
          length <= len_inc;
          if (on_stop || len_inc == FULL) state <= EDIT;
        end
        LINE_READY: begin
          pend <= '0;
          if (line_ack) begin
            length     <= '0;
            overflow   <= 1'b0;
            line_valid <= 1'b0;
            state      <= EDIT;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_line_buffer.sv
module tb_kbd_line_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] code = 8'h00;
  logic       flag = 1'b0, enter = 1'b0, tab = 1'b0, backspace = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic [5:0] length;
  logic       line_valid, overflow;
  logic       line_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  kbd_line_buffer #(.DEPTH(32), .ADDR_W(5), .TAB_STOP(4)) dut (
    .clk(clk), .reset(reset), .code(code), .flag(flag), .enter(enter),
    .tab(tab), .backspace(backspace), .rd_addr(rd_addr), .rd_char(rd_char),
    .length(length), .line_valid(line_valid), .line_ack(line_ack),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 char, 1 backspace, 2 tab, 3 enter
    logic [7:0] c;
    int         len;
    int         ovf;
    int         vld;
  } vec_t;

  vec_t vecs[13];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected data is queued when the address is driven and compared when
  // the registered read data appears one cycle later.
  task automatic rd(input int a, input logic [7:0] e);
    logic [7:0] x;
    rd_addr = 5'(a);
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    check($sformatf("rd_char[%0d]", a), int'(rd_char), int'(x));
  endtask

  task automatic key(input int kind, input logic [7:0] c);
    code = c;
    case (kind)
      0: flag = 1'b1;
      1: backspace = 1'b1;
      2: tab = 1'b1;
      default: enter = 1'b1;
    endcase
    cyc(2);
    flag = 1'b0; backspace = 1'b0; tab = 1'b0; enter = 1'b0;
    cyc(7);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic ack();
    line_ack = 1'b1;
    @(negedge clk);
    line_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{0, 8'h41, 1,  0, 0};
    vecs[1]  = '{0, 8'h42, 2,  0, 0};
    vecs[2]  = '{1, 8'h00, 1,  0, 0};
    vecs[3]  = '{1, 8'h00, 0,  0, 0};
    vecs[4]  = '{1, 8'h00, 0,  0, 0};
    vecs[5]  = '{2, 8'h00, 4,  0, 0};
    vecs[6]  = '{0, 8'h43, 5,  0, 0};
    vecs[7]  = '{2, 8'h00, 8,  0, 0};
    vecs[8]  = '{2, 8'h00, 12, 0, 0};
    vecs[9]  = '{1, 8'h00, 11, 0, 0};
    vecs[10] = '{3, 8'h00, 11, 0, 1};
    vecs[11] = '{0, 8'h44, 11, 0, 1};
    vecs[12] = '{1, 8'h00, 11, 0, 1};

    // Reset state
    cyc(3);
    check("reset length", int'(length), 0);
    check("reset line_valid", int'(line_valid), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset rd_char", int'(rd_char), 0);
    reset = 1'b0;
    cyc(2);

    // Two characters and read-back
    key(0, 8'h41);
    check("len after A", int'(length), 1);
    key(0, 8'h42);
    check("len after B", int'(length), 2);
    rd(0, 8'h41);
    rd(1, 8'h42);

    // Table-driven editing sequence
    do_reset();
    foreach (vecs[i]) begin
      key(vecs[i].kind, vecs[i].c);
      check($sformatf("vec%0d length", i), int'(length), vecs[i].len);
      check($sformatf("vec%0d overflow", i), int'(overflow), vecs[i].ovf);
      check($sformatf("vec%0d line_valid", i), int'(line_valid), vecs[i].vld);
    end
    rd(0, 8'h20);
    rd(3, 8'h20);
    rd(4, 8'h43);
    rd(7, 8'h20);
    rd(10, 8'h20);
    ack();
    check("ack line_valid", int'(line_valid), 0);
    check("ack length", int'(length), 0);

    // Tab from column 1 fills one space per cycle up to column 4
    key(0, 8'h41);
    tab = 1'b1;
    n = 0;
    while (length == 6'd1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("tab fill step1", int'(length), 2);
    cyc(1);
    check("tab fill step2", int'(length), 3);
    cyc(1);
    check("tab fill step3", int'(length), 4);
    tab = 1'b0;
    cyc(6);
    check("tab fill hold", int'(length), 4);
    rd(1, 8'h20);
    rd(2, 8'h20);
    rd(3, 8'h20);
    key(2, 8'h00);
    check("tab on stop", int'(length), 8);

    // line_ack outside LINE_READY is ignored
    ack();
    cyc(2);
    check("ack in EDIT ignored", int'(length), 8);

    // Overflow: 33 characters into 32 slots
    do_reset();
    for (int i = 0; i < 33; i++) key(0, 8'h40 + 8'(i));
    check("ovf length", int'(length), 32);
    check("ovf flag", int'(overflow), 1);
    rd(31, 8'h5F);
    rd(0, 8'h40);
    key(1, 8'h00);
    check("ovf bs length", int'(length), 31);
    check("ovf sticky", int'(overflow), 1);
    key(3, 8'h00);
    check("ovf enter valid", int'(line_valid), 1);
    ack();
    check("ack clears overflow", int'(overflow), 0);
    check("ack clears length", int'(length), 0);

    // Simultaneous tab and char: tab wins, char dropped
    tab = 1'b1; flag = 1'b1; code = 8'h66;
    cyc(2);
    tab = 1'b0; flag = 1'b0;
    cyc(8);
    check("tab beats char", int'(length), 4);
    rd(0, 8'h20);

    // Simultaneous enter and char: enter wins
    enter = 1'b1; flag = 1'b1; code = 8'h77;
    cyc(2);
    enter = 1'b0; flag = 1'b0;
    cyc(8);
    check("enter beats char valid", int'(line_valid), 1);
    check("enter beats char len", int'(length), 4);
    ack();

    // Char arriving during FILL is held and applied afterwards
    key(0, 8'h41);
    tab = 1'b1; code = 8'h55;
    cyc(1);
    flag = 1'b1;
    cyc(1);
    tab = 1'b0;
    cyc(1);
    flag = 1'b0;
    cyc(8);
    check("pending char length", int'(length), 5);
    rd(4, 8'h55);
    rd(2, 8'h20);

    // Reset in the middle of FILL
    do_reset();
    for (int i = 0; i < 4; i++) key(0, 8'h30 + 8'(i));
    tab = 1'b1;
    n = 0;
    while (length != 6'd5 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("fill reached 5", int'(length), 5);
    reset = 1'b1;
    tab = 1'b0;
    #1;
    check("async reset length", int'(length), 0);
    check("async reset valid", int'(line_valid), 0);
    cyc(2);
    reset = 1'b0;
    cyc(5);
    check("fill aborted", int'(length), 0);
    key(0, 8'h43);
    check("post reset length", int'(length), 1);
    rd(0, 8'h43);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
